key_debouncer: RTL
==================

# key_debouncer

- Conditions the four active-low DE0-CV push-buttons before board logic uses them.
- Per key: two-flop synchronization into the `CLOCK_50` domain, a debounce counter, a debounced level, and one-cycle press/release pulses.
- Sits directly upstream of the board-level logic that drives `LEDR`/`HEX0..HEX5`, in place of the raw `KEY` bus.

## Interface

Parameters:
- `N_KEYS`, 4: number of independent keys.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable samples needed to accept a change (20 ms at 50 MHz). Legal range 2..2^24-1. The bench overrides it to 8.

Ports:
- `CLOCK_50`, in, 1: sole clock.
- `RESET_N`, in, 1: asynchronous active-low reset.
- `KEY`, in, N_KEYS: raw buttons, active-low (0 = pressed), asynchronous to the clock.
- `key_level`, out, N_KEYS: debounced level, active-high (1 = pressed). Reset value 0.
- `key_press`, out, N_KEYS: one-cycle pulse when `key_level[i]` goes 0→1. Reset value 0.
- `key_release`, out, N_KEYS: one-cycle pulse when `key_level[i]` goes 1→0. Reset value 0. See Configuration.
- `key_any`, out, 1: OR of `key_level`. Reset value 0.

## Operation

- **Synchronizer:** `KEY[i]` passes through two flops, `s1` and `s2`. Both reset to 1 (released).
- **Per-key state:** two stable states, UP (`key_level`=0) and DOWN (`key_level`=1).
  - Counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1), reset to 0.
  - The "candidate" is `~s2` compared against the current stable level.
- **Each clock edge, per key:**
  - Candidate equals stable level → `cnt` ← 0.
  - Candidate differs and `cnt` == DEBOUNCE_CYCLES-1 → toggle state, `cnt` ← 0, assert `key_press` (UP→DOWN) or `key_release` (DOWN→UP) for exactly this one cycle.
  - Otherwise → `cnt` ← `cnt`+1.
- **Glitch rejection:** a disagreement lasting fewer than DEBOUNCE_CYCLES consecutive samples causes no change and no pulse. Any agreeing sample clears `cnt`; there is no partial credit.
- **Key independence:** keys are fully independent. Several pulses may assert in the same cycle.
- **Key held through reset:** after `RESET_N` deasserts, the key is seen as pressed and debounced normally. It produces a `key_press` at 2+DEBOUNCE_CYCLES cycles.
- **Reset mid-operation:** all state is forced immediately to UP with `cnt`=0 and every output 0. Pending counts are discarded, and no pulse is emitted on reset entry or exit.
- **`key_any`** is registered as the OR of the next-state levels, so it changes in the same cycle as `key_level`.

## Timing

- **Latency:** raw `KEY` edge setup before edge E0 → `key_level` and pulse change after edge E0+1+DEBOUNCE_CYCLES. Total is 2+DEBOUNCE_CYCLES cycles (10 with D=8).
- All outputs are registered. There is no combinational path from `KEY` to any output.
- **Pulse width:** exactly 1 cycle. The minimum spacing between a press and its release pulse is DEBOUNCE_CYCLES cycles.

## Configuration

- **`KEY_DEBOUNCER_RELEASE_PULSE_EN` defined:** `key_release` behaves as specified above.
- **Macro undefined:**
  - `key_release` is tied to constant 0 and no release-pulse flops are built.
  - `key_level` and `key_press` behaviour is unchanged.

## Structure

- **Shared package `key_debouncer_pkg`:**
  - `DEFAULT_DEBOUNCE_CYCLES` = 1_000_000.
  - `KEY_RELEASED` = 1'b1 (raw inactive level).
  - Typedef `key_state_t` {UP, DOWN}.
- **Sub-module `key_debounce_cell`:** one key's synchronizer, counter and state. It is instantiated N_KEYS times in a generate loop. The top adds only the `key_any` register.

## Test plan

Bench uses DEBOUNCE_CYCLES=8 and N_KEYS=4.

1. **Reset values:** assert `RESET_N`=0 with `KEY`=4'hF → all outputs 0. Hold `RESET_N`=1 for 20 cycles with `KEY`=4'hF → outputs stay 0.
2. **Clean press and release:** `KEY[0]` 1→0 held for 20 cycles, then 0→1.
   - `key_level[0]` rises 10 cycles after the falling edge, with a `key_press[0]` pulse of exactly 1 cycle in that same cycle; `key_any`=1.
   - `key_level[0]` falls 10 cycles after the rising edge, with a 1-cycle `key_release[0]` when the macro is defined and 0 otherwise.
3. **Bounce:** `KEY[1]` low for 7 cycles, high for 1 cycle, then low and held.
   - No change through the bounce.
   - `key_level[1]` rises 10 cycles after the final falling edge, with exactly one `key_press[1]` pulse.
4. **Simultaneous keys:** `KEY` 4'hF→4'h0 in one cycle → `key_press` = 4'hF in a single cycle, 10 cycles later.
5. **Reset mid-count:** `KEY[2]` low for 5 cycles, then `RESET_N` pulsed low while `KEY[2]` stays low.
   - Outputs are 0 immediately, with no pulse at reset.
   - After release, `key_press[2]` fires 10 cycles after `RESET_N` rises.
6. **Max count:** DEBOUNCE_CYCLES=2 build; a 1-cycle low glitch on `KEY[3]` → no response. A 2-cycle low → press pulse 4 cycles after the edge.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// Shared constants and state type for the push-button debouncer.
// Optional release pulses are enabled by KEY_DEBOUNCER_RELEASE_PULSE_EN.
package key_debouncer_pkg;

  localparam int   DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam logic KEY_RELEASED            = 1'b1;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } key_state_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: two-flop synchronizer, stability counter, UP/DOWN state and edge pulses.
// Release pulse flop exists only when KEY_DEBOUNCER_RELEASE_PULSE_EN is defined.
module key_debounce_cell
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic level_o,
  output logic level_d_o,
  output logic press_o,
  output logic release_o
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          candidate;

`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
  logic release_q, release_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= KEY_RELEASED;
      s2_q    <= KEY_RELEASED;
      state_q <= UP;
      cnt_q   <= '0;
      press_q <= 1'b0;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
      release_q <= 1'b0;
`endif
    end else begin
      s1_q    <= key_raw_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
      release_q <= release_d;
`endif
    end
  end

  // Raw key is active-low; any agreeing sample discards the partial count.
  assign candidate = ~s2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
    release_d = 1'b0;
`endif
    if (candidate == (state_q == DOWN)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (state_q == UP) begin
        state_d = DOWN;
        press_d = 1'b1;
      end else begin
        state_d = UP;
`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
        release_d = 1'b1;
`endif
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level_o   = (state_q == DOWN);
  assign level_d_o = (state_d == DOWN);
  assign press_o   = press_q;

`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
  assign release_o = release_q;
`else
  assign release_o = 1'b0;
`endif

endmodule

// File: rtl/key_debouncer.sv
// Debounces the active-low KEY bus into levels, press/release pulses and key_any.
// key_release is live only when KEY_DEBOUNCER_RELEASE_PULSE_EN is defined.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              key_any
);

  logic [N_KEYS-1:0] level_d;
  logic              key_any_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      key_debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
        .clk_i     (CLOCK_50),
        .rst_ni    (RESET_N),
        .key_raw_i (KEY[gi]),
        .level_o   (key_level[gi]),
        .level_d_o (level_d[gi]),
        .press_o   (key_press[gi]),
        .release_o (key_release[gi])
      );
    end
  endgenerate

  // Built from next-state levels so key_any moves in the same cycle as key_level.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) key_any_q <= 1'b0;
    else          key_any_q <= |level_d;
  end

  assign key_any = key_any_q;

endmodule
